// File: rtl/jpeg_zigzag_pkg.sv
// jpeg_zigzag_pkg
//   Shared definitions for the encoder-side zigzag scan buffer:
//   - state encodings of the bank-occupancy FSM
//   - default bank count and coefficient width
//   - F_ZigzagIndex: natural (row*8+col) position -> zigzag scan index
package jpeg_zigzag_pkg;

    localparam int NBANK_DEF  = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no committed bank
        S_VALID = 2'd1,   // 1..NBANK-1 committed banks
        S_FULL  = 2'd2,   // every bank committed, writer stalled
        S_INIT  = 2'd3    // one-cycle flush of pointers and flags
    } state_t;

    // Indexed by natural position, yields the zigzag index.
    localparam logic [5:0] ZZ_OF_NAT [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    function automatic logic [5:0] F_ZigzagIndex(input logic [5:0] nat);
        return ZZ_OF_NAT[nat];
    endfunction

endpackage

// File: rtl/jpeg_zigzag_ram.sv
// jpeg_zigzag_ram
//   Simple dual-port RAM, one write port and one synchronous read port.
//   The read register only updates when i_re is high, so the read data
//   holds while the downstream pipeline is stalled.
//   Ports: clk, i_we/i_waddr/i_wdata (write), i_re/i_raddr/o_rdata (read).
module jpeg_zigzag_ram #(
    parameter int DATA_W = 16,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_Mem [2**AW];
    logic [DATA_W-1:0] r_Q;

    always_ff @(posedge clk) begin
        if (i_we) r_Mem[i_waddr] <= i_wdata;
        if (i_re) r_Q <= r_Mem[i_raddr];
    end

    assign o_rdata = r_Q;

endmodule

// File: rtl/jpeg_zigzag_scan.sv
// jpeg_zigzag_scan
//   Buffers quantized 8x8 blocks written in natural order into NBANK banks
//   and streams each committed block out in zigzag order over valid/ready.
//   Optional macro JPEG_ZIGZAG_EOB_EN: stop each block at the last nonzero
//   zigzag index (trailing zeros skipped).
//   Ports:
//     clk, rst (async, active-low)
//     DataInit                     abort, flush all banks
//     DataInEnable/Address/DataIn  one coefficient write, natural index
//     DataInEnd/DataInColor        commit write bank with its component tag
//     DataInIdle                   a free write bank exists
//     DataOutValid/Ready           output handshake
//     DataOut/Index/Color/Last     zigzag-ordered beat
module jpeg_zigzag_scan
    import jpeg_zigzag_pkg::*;
#(
    parameter int NBANK  = NBANK_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DataInit,
    input  logic              DataInEnable,
    input  logic [5:0]        DataInAddress,
    input  logic [2:0]        DataInColor,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataInEnd,
    output logic              DataInIdle,
    output logic              DataOutValid,
    input  logic              DataOutReady,
    output logic [DATA_W-1:0] DataOut,
    output logic [5:0]        DataOutIndex,
    output logic [2:0]        DataOutColor,
    output logic              DataOutLast
);

    localparam int BW = $clog2(NBANK);

    state_t            r_State, w_StateNxt;
    logic [BW-1:0]     r_BankCount, w_CountNxt;
    logic [BW-1:0]     r_WriteBank, r_ReadBank, r_IssBank;
    logic [63:0]       r_Flag [NBANK];
    logic [2:0]        r_BankColor [NBANK];
    logic [5:0]        r_RdIdx;
    logic [1:0]        r_InFlight;   // banks fully issued but not yet released
    logic [BW:0]       w_Committed;
    logic              w_Wr, w_Commit, w_Release, w_Clr;
    logic [5:0]        w_ZZ, w_EndIdx;
    logic              w_S1En, w_S2En, w_Issue, w_IssLast;
    logic [DATA_W-1:0] w_RamQ;

    // read pipeline: stage 1 sits beside the RAM read register
    logic              r_S1Vld, r_S1Last, r_S1Flag;
    logic [5:0]        r_S1Idx;
    logic              r_OutVld, r_OutLast;
    logic [5:0]        r_OutIdx;
    logic [DATA_W-1:0] r_OutData;

    assign DataInIdle = (r_State == S_IDLE) || (r_State == S_VALID);
    assign w_Wr       = DataInEnable && DataInIdle && !DataInit;
    assign w_Commit   = DataInEnd && DataInIdle && !DataInit;
    assign w_Release  = r_OutVld && DataOutReady && r_OutLast;
    assign w_Clr      = DataInit || (r_State == S_INIT);
    assign w_ZZ       = F_ZigzagIndex(DataInAddress);

    always_comb begin
        w_Committed = '0;
        case (r_State)
            S_VALID: w_Committed = {1'b0, r_BankCount} + (BW+1)'(1);
            S_FULL:  w_Committed = (BW+1)'(NBANK);
            default: w_Committed = '0;
        endcase
    end

    // ---------------- occupancy FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_State     <= S_IDLE;
            r_BankCount <= '0;
        end else begin
            r_State     <= w_StateNxt;
            r_BankCount <= w_CountNxt;
        end
    end

    always_comb begin
        w_StateNxt = r_State;
        w_CountNxt = r_BankCount;
        if (DataInit) begin
            w_StateNxt = S_INIT;
            w_CountNxt = '0;
        end else begin
            case (r_State)
                S_IDLE: if (w_Commit) begin
                    w_StateNxt = S_VALID;
                    w_CountNxt = '0;
                end
                S_VALID: begin
                    if (w_Commit && !w_Release) begin
                        w_CountNxt = r_BankCount + 1'b1;
                        if (r_BankCount == BW'(NBANK-2)) w_StateNxt = S_FULL;
                    end else if (w_Release && !w_Commit) begin
                        if (r_BankCount == '0) w_StateNxt = S_IDLE;
                        else                   w_CountNxt = r_BankCount - 1'b1;
                    end
                end
                S_FULL: if (w_Release) begin
                    w_StateNxt = S_VALID;
                    w_CountNxt = BW'(NBANK-2);
                end
                default: begin
                    w_StateNxt = S_IDLE;
                    w_CountNxt = '0;
                end
            endcase
        end
    end

    // ---------------- bank pointers, flags, issue pointer ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_WriteBank <= '0;
            r_ReadBank  <= '0;
            r_IssBank   <= '0;
            r_RdIdx     <= '0;
            r_InFlight  <= '0;
            for (int i = 0; i < NBANK; i++) begin
                r_Flag[i]      <= '0;
                r_BankColor[i] <= '0;
            end
        end else if (w_Clr) begin
            r_WriteBank <= '0;
            r_ReadBank  <= '0;
            r_IssBank   <= '0;
            r_RdIdx     <= '0;
            r_InFlight  <= '0;
            for (int i = 0; i < NBANK; i++) r_Flag[i] <= '0;
        end else begin
            // natural index 0 opens a new block: drop stale flags of the bank
            if (w_Wr) begin
                if (DataInAddress == 6'd0) r_Flag[r_WriteBank] <= 64'd1;
                else                       r_Flag[r_WriteBank][w_ZZ] <= 1'b1;
            end
            if (w_Commit) begin
                r_BankColor[r_WriteBank] <= DataInColor;
                r_WriteBank              <= r_WriteBank + 1'b1;
            end
            if (w_Release) r_ReadBank <= r_ReadBank + 1'b1;
            if (w_Issue) begin
                if (w_IssLast) begin
                    r_RdIdx   <= '0;
                    r_IssBank <= r_IssBank + 1'b1;
                end else begin
                    r_RdIdx   <= r_RdIdx + 6'd1;
                end
            end
            case ({w_Issue && w_IssLast, w_Release})
                2'b10:   r_InFlight <= r_InFlight + 2'd1;
                2'b01:   r_InFlight <= r_InFlight - 2'd1;
                default: r_InFlight <= r_InFlight;
            endcase
        end
    end

`ifdef JPEG_ZIGZAG_EOB_EN
    logic [5:0] r_LastNz [NBANK];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NBANK; i++) r_LastNz[i] <= '0;
        end else if (w_Clr) begin
            for (int i = 0; i < NBANK; i++) r_LastNz[i] <= '0;
        end else if (w_Wr) begin
            if (DataInAddress == 6'd0)
                r_LastNz[r_WriteBank] <= '0;
            else if ((DataIn != '0) && (w_ZZ > r_LastNz[r_WriteBank]))
                r_LastNz[r_WriteBank] <= w_ZZ;
        end
    end

    assign w_EndIdx = r_LastNz[r_IssBank];
`else
    assign w_EndIdx = 6'd63;
`endif

    // ---------------- read pipeline ----------------
    // Each stage advances when it is empty or the stage after it advances,
    // giving one beat per cycle under Ready=1 and a frozen pipe otherwise.
    assign w_S2En    = !r_OutVld || DataOutReady;
    assign w_S1En    = !r_S1Vld || w_S2En;
    assign w_IssLast = (r_RdIdx == w_EndIdx);
    // Banks whose last beat has already been issued stay committed until
    // released, so only the excess over r_InFlight is readable.
    assign w_Issue   = w_S1En && !w_Clr &&
                       (w_Committed > (BW+1)'(r_InFlight));

    jpeg_zigzag_ram #(.DATA_W(DATA_W), .AW(BW+6)) u_ram (
        .clk     (clk),
        .i_we    (w_Wr),
        .i_waddr ({r_WriteBank, w_ZZ}),
        .i_wdata (DataIn),
        .i_re    (w_S1En),
        .i_raddr ({r_IssBank, r_RdIdx}),
        .o_rdata (w_RamQ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_S1Vld   <= 1'b0;
            r_S1Last  <= 1'b0;
            r_S1Flag  <= 1'b0;
            r_S1Idx   <= '0;
            r_OutVld  <= 1'b0;
            r_OutLast <= 1'b0;
            r_OutIdx  <= '0;
            r_OutData <= '0;
        end else if (w_Clr) begin
            r_S1Vld   <= 1'b0;
            r_OutVld  <= 1'b0;
        end else begin
            if (w_S1En) begin
                r_S1Vld  <= w_Issue;
                r_S1Idx  <= r_RdIdx;
                r_S1Last <= w_IssLast;
                r_S1Flag <= r_Flag[r_IssBank][r_RdIdx];
            end
            if (w_S2En) begin
                r_OutVld  <= r_S1Vld;
                r_OutIdx  <= r_S1Idx;
                r_OutLast <= r_S1Last;
                r_OutData <= r_S1Flag ? w_RamQ : '0;
            end
        end
    end

    assign DataOutValid = r_OutVld;
    assign DataOut      = r_OutData;
    assign DataOutIndex = r_OutIdx;
    assign DataOutLast  = r_OutLast;
    // The bank at the output is always the oldest unreleased one.
    assign DataOutColor = r_BankColor[r_ReadBank];

endmodule

// File: tb/tb_jpeg_zigzag_scan.sv
// tb_jpeg_zigzag_scan
//   Scoreboard bench: blocks are modelled in natural order, expanded to
//   zigzag beats on commit and queued; a negedge monitor pops and compares
//   every accepted beat and checks hold-stability under backpressure.
//   Honours JPEG_ZIGZAG_EOB_EN when computing expected block length.
module tb_jpeg_zigzag_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DataInit = 1'b0;
    logic        DataInEnable = 1'b0;
    logic [5:0]  DataInAddress = '0;
    logic [2:0]  DataInColor = '0;
    logic [15:0] DataIn = '0;
    logic        DataInEnd = 1'b0;
    logic        DataInIdle;
    logic        DataOutValid;
    logic        DataOutReady = 1'b0;
    logic [15:0] DataOut;
    logic [5:0]  DataOutIndex;
    logic [2:0]  DataOutColor;
    logic        DataOutLast;

    always #5 clk = ~clk;

    jpeg_zigzag_scan #(.NBANK(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .DataInit(DataInit),
        .DataInEnable(DataInEnable), .DataInAddress(DataInAddress),
        .DataInColor(DataInColor), .DataIn(DataIn), .DataInEnd(DataInEnd),
        .DataInIdle(DataInIdle), .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady), .DataOut(DataOut),
        .DataOutIndex(DataOutIndex), .DataOutColor(DataOutColor),
        .DataOutLast(DataOutLast)
    );

    // zigzag index -> natural position (JPEG scan order)
    int ZZ_ORDER [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct packed {
        logic [15:0] d;
        logic [5:0]  i;
        logic [2:0]  c;
        logic        l;
    } beat_t;

    beat_t       sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_val [64];
    logic        m_wr  [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // write that the DUT is expected to honour
    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        m_val[a] = d;
        m_wr[a]  = 1'b1;
        DataInEnable = 1'b1; DataInAddress = a; DataIn = d;
        step();
        DataInEnable = 1'b0;
    endtask

    // write that the DUT is expected to drop (model untouched)
    task automatic wr_raw(input logic [5:0] a, input logic [15:0] d);
        DataInEnable = 1'b1; DataInAddress = a; DataIn = d;
        step();
        DataInEnable = 1'b0;
    endtask

    task automatic push_blk(input logic [2:0] c);
        int    last;
        beat_t b;
        last = 63;
`ifdef JPEG_ZIGZAG_EOB_EN
        last = 0;
        for (int k = 0; k < 64; k++)
            if (m_wr[ZZ_ORDER[k]] && m_val[ZZ_ORDER[k]] != 16'h0) last = k;
`endif
        for (int k = 0; k <= last; k++) begin
            b.d = m_wr[ZZ_ORDER[k]] ? m_val[ZZ_ORDER[k]] : 16'h0;
            b.i = 6'(k);
            b.c = c;
            b.l = (k == last);
            sbq.push_back(b);
        end
        for (int n = 0; n < 64; n++) m_wr[n] = 1'b0;
    endtask

    task automatic endblk(input logic [2:0] c);
        push_blk(c);
        DataInEnd = 1'b1; DataInColor = c;
        step();
        DataInEnd = 1'b0;
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (sbq.size() != 0 && c < 1000) begin
            step();
            c++;
        end
        chk({nm, "_drain_left"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
        repeat (3) step();
    endtask

    // ---------------- monitor ----------------
    logic  hold = 1'b0;
    beat_t held;

    always @(negedge clk) begin
        beat_t a, e;
        if (rst) begin
            a = {DataOut, DataOutIndex, DataOutColor, DataOutLast};
            if (DataOutValid) begin
                if (hold) chk("hold_stable", 32'(a), 32'(held));
                if (DataOutReady) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %0h expected none", a);
                    end else begin
                        e = sbq.pop_front();
                        chk("beat", 32'(a), 32'(e));
                    end
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = a;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        for (int n = 0; n < 64; n++) begin
            m_wr[n]  = 1'b0;
            m_val[n] = '0;
        end

        // reset state
        step();
        chk("rst_idle",  32'(DataInIdle), 32'd1);
        chk("rst_valid", 32'(DataOutValid), 32'd0);
        chk("rst_out",   32'({DataOut, DataOutIndex, DataOutColor, DataOutLast}), 32'd0);
        rst = 1'b1;
        step();

        // ramp: natural n holds n, latency 2 from End
        DataOutReady = 1'b1;
        for (int n = 0; n < 64; n++) wr(6'(n), 16'(n));
        endblk(3'd2);
        chk("lat_e0", 32'(DataOutValid), 32'd0);
        step();
        chk("lat_e1", 32'(DataOutValid), 32'd0);
        step();
        chk("lat_e2", 32'(DataOutValid), 32'd1);
        chk("ramp_first_idx", 32'(DataOutIndex), 32'd0);
        drain("ramp");

        // sparse: only natural 0 and 9 written
        wr(6'd0, 16'd100);
        wr(6'd9, 16'hFFFB);
        endblk(3'd5);
        drain("sparse");

        // backpressure: Ready 1,0,0,1 repeating
        for (int n = 0; n < 64; n++) wr(6'(n), 16'(n * 3 + 7));
        endblk(3'd1);
        for (int k = 0; k < 600 && sbq.size() != 0; k++) begin
            DataOutReady = ((k % 4) == 0) || ((k % 4) == 3);
            step();
        end
        DataOutReady = 1'b1;
        drain("bp");

        // full: four blocks with Ready low
        DataOutReady = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wr(6'd0, 16'(1000 + b));
            wr(6'd20, 16'(b + 1));
            endblk(3'(b + 1));
        end
        chk("full_idle", 32'(DataInIdle), 32'd0);
        wr_raw(6'd0, 16'h7777);
        wr_raw(6'd1, 16'h6666);
        DataInEnd = 1'b1; DataInColor = 3'd7;
        step();
        DataInEnd = 1'b0;
        chk("full_idle_after_ignored", 32'(DataInIdle), 32'd0);
        DataOutReady = 1'b1;
        c = 0;
        while (!DataInIdle && c < 300) begin
            step();
            c++;
        end
        chk("full_release_idle", 32'(DataInIdle), 32'd1);
        wr(6'd0, 16'h0055);
        wr(6'd7, 16'hFFFF);
        endblk(3'd7);
        drain("full");

        // simultaneous commit and release at BankCount=1
        DataOutReady = 1'b0;
        wr(6'd0, 16'd11); wr(6'd1, 16'd12); endblk(3'd1);
        wr(6'd0, 16'd21); wr(6'd2, 16'd22); endblk(3'd2);
        wr(6'd0, 16'd31); wr(6'd8, 16'd32);
        DataOutReady = 1'b1;
        c = 0;
        while (!(DataOutValid && DataOutLast && DataOutColor == 3'd1) && c < 300) begin
            step();
            c++;
        end
        chk("sim_wait_last", 32'(c < 300), 32'd1);
        endblk(3'd3);
        chk("sim_state", 32'(dut.r_State), 32'd1);
        chk("sim_count", 32'(dut.r_BankCount), 32'd1);
        drain("sim");

        // init mid-stream at beat 30
        for (int n = 0; n < 64; n++) wr(6'(n), 16'(n + 200));
        endblk(3'd4);
        c = 0;
        while (!(DataOutValid && DataOutIndex == 6'd30) && c < 300) begin
            step();
            c++;
        end
        chk("init_wait_beat30", 32'(c < 300), 32'd1);
        DataInit = 1'b1;
        step();
        DataInit = 1'b0;
        sbq.delete();
        chk("init_valid_drop", 32'(DataOutValid), 32'd0);
        chk("init_state_init", 32'(dut.r_State), 32'd3);
        step();
        chk("init_state_idle", 32'(dut.r_State), 32'd0);
        chk("init_idle", 32'(DataInIdle), 32'd1);
        chk("init_wbank", 32'(dut.r_WriteBank), 32'd0);
        // no natural-0 write: flags must have been cleared by the init
        wr(6'd5, 16'h1234);
        wr(6'd12, 16'hABCD);
        endblk(3'd6);
        drain("init");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
